// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises IRQ lines, latches pending requests (edge/level),
// masks, fixed-priority arbitrates and runs the ACK/EOI handshake with the CPU.
module irq_ctrl #(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [4:2]      ADD_I,
  input  logic            WE_I,
  input  logic [31:0]     DAT_I,
  output logic [31:0]     DAT_O,
  input  logic [NSRC-1:0] IRQ_I,
  input  logic            ACK_I,
  output logic            INT_O,
  output logic [IDW-1:0]  IRQ_ID_O
);

  localparam logic [IDW:0] NONE = (IDW+1)'(NSRC);

  // Index of the lowest set bit, NONE when the vector is empty.
  function automatic logic [IDW:0] lowest_set(input logic [NSRC-1:0] v);
    logic [IDW:0] r;
    r = NONE;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = (IDW+1)'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [NSRC-1:0] onehot(input logic [IDW:0] idx);
    logic [NSRC-1:0] r;
    r = {NSRC{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (idx == (IDW+1)'(i)) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [NSRC-1:0] s1_r, s2_r, mask_r, mode_r, pend_r, isr_r;
  logic            int_r;
  logic [IDW-1:0]  id_r;

  logic [NSRC-1:0] cand_s, set_s, clr_s, pend_nx_s, isr_nx_s, wdat_s;
  logic [IDW:0]    win_s, top_s;
  logic [IDW-1:0]  vec_id_s;
  logic            cand_any_s, valid_s, take_s;
  logic            wr_mask_s, wr_mode_s, wr_pend_s, wr_isr_s, wr_force_s;
  logic            unused_s;

  assign wdat_s     = DAT_I[NSRC-1:0];
  assign unused_s   = ^DAT_I[31:NSRC];
  assign cand_s     = pend_r & mask_r;
  assign cand_any_s = |cand_s;
  assign win_s      = lowest_set(cand_s);
  assign top_s      = lowest_set(isr_r);
  assign valid_s    = cand_any_s && (win_s < top_s);
  // An ACK only counts against a registered request; guard against an empty candidate set.
  assign take_s     = ACK_I & int_r & cand_any_s;
  assign vec_id_s   = cand_any_s ? win_s[IDW-1:0] : {IDW{1'b0}};

  assign wr_mask_s  = WE_I && (ADD_I == 3'd0);
  assign wr_mode_s  = WE_I && (ADD_I == 3'd1);
  assign wr_pend_s  = WE_I && (ADD_I == 3'd2);
  assign wr_isr_s   = WE_I && (ADD_I == 3'd3);
  assign wr_force_s = WE_I && (ADD_I == 3'd5);

  // Next pending/in-service state; set beats clear, EOI uses the pre-edge ISR.
  always_comb begin
    set_s = (s1_r & ~s2_r) | (wr_force_s ? wdat_s : {NSRC{1'b0}});
    clr_s = (wr_pend_s ? wdat_s : {NSRC{1'b0}}) |
            (take_s ? onehot(win_s) : {NSRC{1'b0}});
    pend_nx_s = (mode_r & ((pend_r & ~clr_s) | set_s)) | (~mode_r & s1_r);
    isr_nx_s = isr_r;
    if (wr_isr_s) begin
      isr_nx_s = isr_r & ~onehot(top_s);
    end else begin
      isr_nx_s = isr_r;
    end
    if (take_s) begin
      isr_nx_s = isr_nx_s | onehot(win_s);
    end else begin
      isr_nx_s = isr_nx_s;
    end
  end

  // Register file read mux.
  always_comb begin
    DAT_O = 32'd0;
    case (ADD_I)
      3'd0:    DAT_O = {{(32-NSRC){1'b0}}, mask_r};
      3'd1:    DAT_O = {{(32-NSRC){1'b0}}, mode_r};
      3'd2:    DAT_O = {{(32-NSRC){1'b0}}, pend_r};
      3'd3:    DAT_O = {{(32-NSRC){1'b0}}, isr_r};
      3'd4:    DAT_O = {valid_s, {(31-IDW){1'b0}}, vec_id_s};
      default: DAT_O = 32'd0;
    endcase
  end

  // State registers; reset wins over any concurrent ACK.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      s1_r   <= {NSRC{1'b0}};
      s2_r   <= {NSRC{1'b0}};
      mask_r <= {NSRC{1'b0}};
      mode_r <= {NSRC{1'b0}};
      pend_r <= {NSRC{1'b0}};
      isr_r  <= {NSRC{1'b0}};
      int_r  <= 1'b0;
      id_r   <= {IDW{1'b0}};
    end else begin
      s1_r   <= IRQ_I;
      s2_r   <= s1_r;
      mask_r <= wr_mask_s ? wdat_s : mask_r;
      mode_r <= wr_mode_s ? wdat_s : mode_r;
      pend_r <= pend_nx_s;
      isr_r  <= isr_nx_s;
      int_r  <= valid_s;
      id_r   <= take_s ? win_s[IDW-1:0] : id_r;
    end
  end

  assign INT_O    = int_r;
  assign IRQ_ID_O = id_r;

endmodule
